// File: rtl/sevenseg_scan_ctrl_pkg.sv
// sevenseg_scan_ctrl_pkg: segment patterns and output polarity helper for the scan controller
package sevenseg_scan_ctrl_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [7:0] drive8(input logic [7:0] v, input bit active_low);
    return active_low ? ~v : v;
  endfunction
endpackage

// File: rtl/sevenseg_scan_ctrl_hex_decode.sv
// seg7_hex_decode: hex nibble to active-high gfedcba segment pattern
module seg7_hex_decode
  import sevenseg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[int'(nibble)*7 +: 7];
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed N-digit seven-segment scanner with frame buffering, LZ blanking and PWM
module sevenseg_scan_ctrl
  import sevenseg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int BRIGHT_W   = 3,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_mask,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              Ca,
  output logic                    frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0] CA_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [NUM_DIGITS-1:0][3:0] shadow_data;
  logic [NUM_DIGITS-1:0][3:0] frame_data;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] frame_dp;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [NUM_DIGITS-1:0] an_next;
  logic lz_en;
  logic upper_zero;
  logic slot_tick;
  logic wrap;
  logic [6:0] seg_hex;
  logic [7:0] ca_next;
  assign slot_tick = slot_cnt == SLOT_LAST;
  assign wrap = slot_tick && idx == IDX_LAST;
  // Walk down from the top digit; a digit blanks while everything above it is still zero.
  always_comb begin
    lz_blank = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      upper_zero = upper_zero && frame_data[k] == 4'h0;
      lz_blank[k] = lz_en && upper_zero;
    end
  end
  seg7_hex_decode u_dec (
    .nibble(frame_data[idx]),
    .seg   (seg_hex)
  );
  assign ca_next = {frame_dp[idx], lz_blank[idx] ? SEG_BLANK : seg_hex};
  assign an_next = (en_mask[idx] && pwm_cnt <= bright) ? NUM_DIGITS'(1) << idx : '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt <= '0;
      idx <= '0;
      pwm_cnt <= '0;
      shadow_data <= '0;
      shadow_dp <= '0;
      frame_data <= '0;
      frame_dp <= '0;
      lz_en <= 1'b0;
      frame_done <= 1'b0;
      AN <= AN_OFF;
      Ca <= CA_OFF;
    end else begin
      slot_cnt <= slot_tick ? '0 : slot_cnt + 1'b1;
      if (slot_tick) idx <= wrap ? '0 : idx + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (load) begin
        shadow_data <= data;
        shadow_dp <= dp_in;
      end
      if (wrap) begin
        frame_data <= shadow_data;
        frame_dp <= shadow_dp;
        lz_en <= blank_lz;
      end
      frame_done <= wrap;
      AN <= ACTIVE_LOW ? ~an_next : an_next;
      Ca <= drive8(ca_next, ACTIVE_LOW);
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed checks of scanning, buffering, blanking, PWM and reset
module tb_sevenseg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic blank_lz = 1'b0;
  logic [31:0] data = '0;
  logic [7:0] dp_in = '0;
  logic [7:0] en_mask = 8'hFF;
  logic [2:0] bright = 3'd7;
  logic [7:0] an, ca, an16, ca16;
  logic fd, fd16;
  int t = 0;
  int tests = 0;
  int fails = 0;
  localparam logic [7:0] CA_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  always #5 clk = ~clk;
  sevenseg_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(4), .BRIGHT_W(3), .ACTIVE_LOW(1)) u_dut (
    .CLK(clk), .RST(rst), .load(load), .data(data), .dp_in(dp_in), .en_mask(en_mask),
    .blank_lz(blank_lz), .bright(bright), .AN(an), .Ca(ca), .frame_done(fd)
  );
  sevenseg_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(16), .BRIGHT_W(3), .ACTIVE_LOW(1)) u_dut16 (
    .CLK(clk), .RST(rst), .load(load), .data(data), .dp_in(dp_in), .en_mask(en_mask),
    .blank_lz(blank_lz), .bright(bright), .AN(an16), .Ca(ca16), .frame_done(fd16)
  );
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask
  function automatic logic [7:0] exp_ca(input logic [31:0] d, input logic [7:0] dp, input bit lz, input int k);
    logic [7:0] c;
    logic [31:0] hi;
    hi = d >> (4 * k);
    c = (lz && k > 0 && hi == 0) ? 8'hFF : CA_TBL[hi[3:0]];
    if (dp[k]) c[7] = 1'b0;
    return c;
  endfunction
  function automatic logic [7:0] exp_an(input int k, input bit on);
    logic [7:0] one;
    one = 8'h01;
    return on ? ~(one << k) : 8'hFF;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (an !== 8'hFF || ca !== 8'hFF || fd !== 1'b0 || an16 !== 8'hFF) begin
      fails++;
      $display("FAIL reset AN=%h Ca=%h fd=%b AN16=%h required FF FF 0 FF", an, ca, fd, an16);
    end
    rst = 1'b0;
    t = 0;
  endtask
  task automatic test_scan();
    int d;
    repeat (40) begin
      tick();
      d = ((t - 1) / 4) % 8;
      tests++;
      if (an !== exp_an(d, 1) || ca !== 8'hC0 || fd !== (t == 32)) begin
        fails++;
        $display("FAIL scan t=%0d AN=%h/%h Ca=%h/C0 fd=%b/%b", t, an, exp_an(d, 1), ca, fd, t == 32);
      end
    end
  endtask
  task automatic test_load_midframe();
    int d;
    logic [31:0] ed;
    repeat (56) begin
      load = t == 40;
      if (t == 40) data = 32'h12345678;
      tick();
      d = ((t - 1) / 4) % 8;
      ed = ((t - 1) / 32) >= 2 ? 32'h12345678 : 32'h0;
      tests++;
      if (an !== exp_an(d, 1) || ca !== exp_ca(ed, 8'h00, 0, d) || fd !== (t % 32 == 0)) begin
        fails++;
        $display("FAIL load t=%0d AN=%h/%h Ca=%h/%h fd=%b", t, an, exp_an(d, 1), ca, exp_ca(ed, 8'h00, 0, d), fd);
      end
    end
    load = 1'b0;
  endtask
  task automatic test_blank_lz();
    int d;
    int f;
    logic [31:0] ed;
    bit el;
    repeat (128) begin
      load = t == 96 || t == 160;
      if (t == 96) begin
        blank_lz = 1'b1;
        data = 32'h000000A0;
      end
      if (t == 160) data = 32'h0;
      tick();
      d = ((t - 1) / 4) % 8;
      f = (t - 1) / 32;
      ed = f == 3 ? 32'h12345678 : f == 6 ? 32'h0 : 32'hA0;
      el = f != 3;
      tests++;
      if (an !== exp_an(d, 1) || ca !== exp_ca(ed, 8'h00, el, d)) begin
        fails++;
        $display("FAIL blank_lz t=%0d AN=%h/%h Ca=%h/%h", t, an, exp_an(d, 1), ca, exp_ca(ed, 8'h00, el, d));
      end
    end
    load = 1'b0;
  endtask
  task automatic test_dp_wrap();
    int d;
    logic [31:0] ed;
    logic [7:0] ep;
    repeat (96) begin
      load = t == 255;
      if (t == 255) begin
        data = 32'h5;
        dp_in = 8'h01;
      end
      tick();
      d = ((t - 1) / 4) % 8;
      ed = ((t - 1) / 32) == 9 ? 32'h5 : 32'h0;
      ep = ((t - 1) / 32) == 9 ? 8'h01 : 8'h00;
      tests++;
      if (an !== exp_an(d, 1) || ca !== exp_ca(ed, ep, 1, d) || fd !== (t % 32 == 0)) begin
        fails++;
        $display("FAIL dp_wrap t=%0d AN=%h/%h Ca=%h/%h fd=%b", t, an, exp_an(d, 1), ca, exp_ca(ed, ep, 1, d), fd);
      end
    end
    load = 1'b0;
  endtask
  task automatic test_pwm();
    int d;
    int d16;
    bit on;
    bit on16;
    bright = 3'd0;
    en_mask = 8'hF0;
    repeat (128) begin
      tick();
      d = ((t - 1) / 4) % 8;
      d16 = ((t - 1) / 16) % 8;
      on = (t - 1) % 8 == 0 && en_mask[d];
      on16 = (t - 1) % 8 == 0 && en_mask[d16];
      tests++;
      if (an !== exp_an(d, on) || an16 !== exp_an(d16, on16)) begin
        fails++;
        $display("FAIL pwm t=%0d AN=%h/%h AN16=%h/%h", t, an, exp_an(d, on), an16, exp_an(d16, on16));
      end
    end
    bright = 3'd7;
    en_mask = 8'hFF;
  endtask
  task automatic test_reset_midframe();
    int d;
    logic [31:0] ed;
    load = 1'b1;
    data = 32'h12345678;
    blank_lz = 1'b0;
    tick();
    load = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    load = 1'b1;
    data = 32'h87654321;
    dp_in = 8'hFF;
    tick();
    tests++;
    if (an !== 8'hFF || ca !== 8'hFF || fd !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid AN=%h Ca=%h fd=%b required FF FF 0", an, ca, fd);
    end
    rst = 1'b0;
    load = 1'b0;
    dp_in = 8'h00;
    t = 0;
    repeat (96) begin
      load = t == 39;
      if (t == 39) data = 32'h9;
      tick();
      d = ((t - 1) / 4) % 8;
      ed = ((t - 1) / 32) >= 2 ? 32'h9 : 32'h0;
      tests++;
      if (an !== exp_an(d, 1) || ca !== exp_ca(ed, 8'h00, 0, d) || fd !== (t % 32 == 0)) begin
        fails++;
        $display("FAIL after_reset t=%0d AN=%h/%h Ca=%h/%h fd=%b", t, an, exp_an(d, 1), ca, exp_ca(ed, 8'h00, 0, d), fd);
      end
    end
    load = 1'b0;
  endtask
  initial begin
    test_reset();
    test_scan();
    test_load_midframe();
    test_blank_lz();
    test_dp_wrap();
    test_pwm();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
